uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the UART TX FIFO write port between two requesters: the RX echo path and the time-print path.
//   A time print sends the 10-byte ASCII message "HH:MM:SS\r\n" built from the stopwatch/watch outputs
//   data_hour/data_min/data_sec. Sits between the stopwatch datapath and the UART TX FIFO, next to the RX decoder.
// PARAMETERS
//   PERIOD_CYCLES  100_000_000  auto-print interval in clk cycles (used only with AUTO_PRINT_EN)
// PORTS
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   echo_data    in   8  received byte to echo back
//   echo_valid   in   1  one-cycle pulse: echo_data is valid
//   print_req    in   1  one-cycle pulse: request a time print
//   data_hour    in   5  hour, binary, 0..23
//   data_min     in   6  minute, binary, 0..59
//   data_sec     in   6  second, binary, 0..59
//   fifo_full    in   1  TX FIFO full; no push may occur while high
//   fifo_wdata   out  8  byte to write
//   fifo_push    out  1  write strobe, one byte per high cycle
//   busy         out  1  high while in state ECHO or MSG
//   echo_drop    out  1  one-cycle pulse: an echo byte was lost
// BEHAVIOUR
//   Reset: state=IDLE. Echo holding register empty. Print-pending flag clear. Byte index 0.
//     Snapshot registers 0. Outputs fifo_push=0, fifo_wdata=0, busy=0, echo_drop=0.
//   States: IDLE, ECHO, MSG.
//   Echo capture: echo_valid loads a 1-deep holding register (echo_pend=1).
//     If echo_pend is already 1 and the register is not being emptied in the same cycle:
//       the new byte is discarded, the held byte is kept, and echo_drop pulses in the next cycle.
//   Print capture: print_req sets print_pend. A print_req while print_pend=1 or while in MSG
//     collapses into the single pending print.
//   IDLE arbitration, evaluated each cycle:
//     echo_pend=1 -> ECHO.
//     else print_pend=1 -> MSG; on that edge snapshot hour/min/sec, idx=0, print_pend=0.
//     Echo wins when both are pending, so a simultaneous echo_valid+print_req is serviced as echo first, then print.
//   ECHO: fifo_push = !fifo_full; fifo_wdata = held byte.
//     On the push cycle: echo_pend=0, go to IDLE.
//   MSG: fifo_push = !fifo_full; fifo_wdata = byte[idx].
//     idx advances only on a push. After the push of idx=9, go to IDLE.
//     A pending echo is then sent before any further print (fairness).
//   fifo_push and fifo_wdata are combinational from the registered state/idx/snapshot and fifo_full.
//     fifo_push is never 1 while fifo_full=1. fifo_wdata=0 whenever fifo_push=0.
//   Byte map: 0,1 hour tens/ones; 2 ':'(0x3A); 3,4 min; 5 ':'; 6,7 sec; 8 0x0D; 9 0x0A.
//     Each digit = 0x30 + (v/10) or 0x30 + (v%10).
//     Conversion is exact for v=0..63; out-of-range inputs are still converted arithmetically.
//   Latency: a print_req sampled in IDLE with no echo pending gives its first push in the next cycle.
//     With fifo_full=0 the full message takes 10 consecutive cycles.
//   The snapshot is frozen for the whole message, so a seconds rollover mid-message cannot tear the time.
//   fifo_full may stall any byte for any number of cycles; bytes are never skipped or repeated.
//   A synchronous reset mid-message aborts immediately. Pending echo and print are cleared.
//     No further bytes of the aborted message are pushed.
// CONFIGURATION
//   AUTO_PRINT_EN defined:
//     Free-running counter 0..PERIOD_CYCLES-1; its wrap sets print_pend exactly like print_req.
//     The counter is cleared by reset.
//   AUTO_PRINT_EN undefined: no counter; prints occur only on print_req.
// TESTING
//   1. hour=12, min=34, sec=56, print_req, fifo_full=0
//      -> 10 pushes in consecutive cycles: 31 32 3A 33 34 3A 35 36 0D 0A.
//   2. Same print with fifo_full=1 for 5 cycles at idx=4
//      -> no push while full; resumes with 0x34; total exactly 10 pushes.
//   3. echo_valid(0x41) and print_req in the same IDLE cycle
//      -> push 0x41 first, then the 10-byte message.
//   4. Two echo_valid pulses (0x61, 0x62) during MSG
//      -> echo_drop pulses once; 0x61 is pushed right after 0x0A; 0x62 is never pushed.
//   5. reset asserted after the 3rd byte of a message
//      -> next cycle all outputs 0, state IDLE; no remaining bytes are pushed.
//   6. AUTO_PRINT_EN with PERIOD_CYCLES=20, hour=0, min=0, sec=7
//      -> message "00:00:07\r\n" begins every 20 cycles.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// TX FIFO write-port bundle shared by the scheduler and the UART TX FIFO.
// The master drives the byte and strobe; the slave reports full.
interface uart_tx_scheduler_if;
    logic [7:0] fifo_wdata;
    logic       fifo_push;
    logic       fifo_full;

    modport master (
        output fifo_wdata,
        output fifo_push,
        input  fifo_full
    );

    modport slave (
        input  fifo_wdata,
        input  fifo_push,
        output fifo_full
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Arbitrates the UART TX FIFO between RX echo and "HH:MM:SS\r\n" time prints.
// Optional AUTO_PRINT_EN adds a periodic print every PERIOD_CYCLES clocks.
module uart_tx_scheduler #(
    parameter int PERIOD_CYCLES = 100_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  echo_data,
    input  logic                        echo_valid,
    input  logic                        print_req,
    input  logic [4:0]                  data_hour,
    input  logic [5:0]                  data_min,
    input  logic [5:0]                  data_sec,
    uart_tx_scheduler_if.master         fifo,
    output logic                        busy,
    output logic                        echo_drop
);

    typedef enum logic [1:0] {IDLE, ECHO, MSG} state_t;

    state_t     state;
    logic [7:0] echo_buf;
    logic       echo_pend;
    logic       print_pend;
    logic [3:0] idx;
    logic [4:0] snap_hour;
    logic [5:0] snap_min;
    logic [5:0] snap_sec;
    logic       auto_tick;
    logic       push;
    logic [7:0] msg_byte;
    logic       echo_pop;
    logic       print_in;
    logic       echo_any;
    logic       start_msg;

    if (PERIOD_CYCLES < 2) begin : g_bad_period
        $error("PERIOD_CYCLES must be at least 2");
    end

`ifdef AUTO_PRINT_EN
    localparam int CW = $clog2(PERIOD_CYCLES);
    logic [CW-1:0] tick_cnt;

    assign auto_tick = (tick_cnt == CW'(PERIOD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (auto_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end
`else
    assign auto_tick = 1'b0;
`endif

    function automatic logic [7:0] tens(input logic [5:0] v);
        return 8'h30 + 8'(v / 6'd10);
    endfunction

    function automatic logic [7:0] ones(input logic [5:0] v);
        return 8'h30 + 8'(v % 6'd10);
    endfunction

    always_comb begin
        msg_byte = 8'h00;
        case (idx)
            4'd0: msg_byte = tens({1'b0, snap_hour});
            4'd1: msg_byte = ones({1'b0, snap_hour});
            4'd2: msg_byte = 8'h3A;
            4'd3: msg_byte = tens(snap_min);
            4'd4: msg_byte = ones(snap_min);
            4'd5: msg_byte = 8'h3A;
            4'd6: msg_byte = tens(snap_sec);
            4'd7: msg_byte = ones(snap_sec);
            4'd8: msg_byte = 8'h0D;
            4'd9: msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    end

    assign push      = (state != IDLE) && !fifo.fifo_full;
    assign busy      = (state != IDLE);
    assign echo_pop  = (state == ECHO) && push;
    assign print_in  = print_req | auto_tick;
    assign echo_any  = echo_pend | echo_valid;
    assign start_msg = (state == IDLE) && !echo_any
                       && (print_pend | print_in);

    assign fifo.fifo_push  = push;
    assign fifo.fifo_wdata = !push ? 8'h00 :
                             (state == ECHO) ? echo_buf : msg_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            echo_buf   <= 8'h00;
            echo_pend  <= 1'b0;
            print_pend <= 1'b0;
            idx        <= 4'd0;
            snap_hour  <= 5'd0;
            snap_min   <= 6'd0;
            snap_sec   <= 6'd0;
            echo_drop  <= 1'b0;
        end else begin
            // A byte arriving while the slot is held and not draining is lost.
            echo_drop <= echo_valid && echo_pend && !echo_pop;

            if (echo_valid && (!echo_pend || echo_pop)) begin
                echo_buf  <= echo_data;
                echo_pend <= 1'b1;
            end else if (echo_pop) begin
                echo_pend <= 1'b0;
            end

            if (start_msg)
                print_pend <= 1'b0;
            else if (print_in)
                print_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (echo_any) begin
                        state <= ECHO;
                    end else if (start_msg) begin
                        state     <= MSG;
                        idx       <= 4'd0;
                        snap_hour <= data_hour;
                        snap_min  <= data_min;
                        snap_sec  <= data_sec;
                    end
                end
                ECHO: begin
                    if (push)
                        state <= IDLE;
                end
                MSG: begin
                    if (push) begin
                        if (idx == 4'd9) begin
                            state <= IDLE;
                            idx   <= 4'd0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed-vector bench for uart_tx_scheduler.
// Define AUTO_PRINT_EN to exercise the periodic print instead of the manual tests.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] echo_data = 8'h00;
    logic       echo_valid = 1'b0;
    logic       print_req = 1'b0;
    logic [4:0] data_hour = 5'd0;
    logic [5:0] data_min = 6'd0;
    logic [5:0] data_sec = 6'd0;
    logic       busy;
    logic       echo_drop;

    uart_tx_scheduler_if fifo ();

    uart_tx_scheduler #(.PERIOD_CYCLES(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .echo_data  (echo_data),
        .echo_valid (echo_valid),
        .print_req  (print_req),
        .data_hour  (data_hour),
        .data_min   (data_min),
        .data_sec   (data_sec),
        .fifo       (fifo.master),
        .busy       (busy),
        .echo_drop  (echo_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int drops = 0;
    int full_push = 0;
    logic [7:0] q[$];
    int pc[$];

    localparam logic [79:0] MSG_123456 = 80'h31_32_3A_33_34_3A_35_36_0D_0A;
    localparam logic [79:0] MSG_000007 = 80'h30_30_3A_30_30_3A_30_37_0D_0A;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo.fifo_push) begin
            q.push_back(fifo.fifo_wdata);
            pc.push_back(cyc);
            if (fifo.fifo_full) full_push++;
        end
        if (echo_drop) drops++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_q(input int n, input int lim);
        int k;
        k = 0;
        while (q.size() < n && k < lim) begin
            tick();
            k++;
        end
        if (q.size() < n) check("timeout", q.size(), n);
    endtask

    task automatic check_msg(input string tag, input int off,
                             input logic [79:0] exp);
        logic [7:0] b;
        for (int i = 0; i < 10; i++) begin
            b = (off + i < q.size()) ? q[off + i] : 8'hXX;
            check($sformatf("%s[%0d]", tag, i), b, exp[79 - 8 * i -: 8]);
        end
    endtask

    task automatic pulse_print();
        print_req = 1'b1;
        tick();
        print_req = 1'b0;
    endtask

    task automatic clear_log();
        q.delete();
        pc.delete();
    endtask

    int n0;

    initial begin
        fifo.fifo_full = 1'b0;
        ticks(2);
        check("rst_push", fifo.fifo_push, 0);
        check("rst_wdata", fifo.fifo_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", echo_drop, 0);
        reset = 1'b0;
        tick();
        data_hour = 5'd12;
        data_min  = 6'd34;
        data_sec  = 6'd56;

`ifndef AUTO_PRINT_EN
        // basic message, back-to-back bytes
        clear_log();
        n0 = cyc;
        pulse_print();
        check("t1_busy", busy, 1);
        ticks(12);
        check("t1_count", q.size(), 10);
        check_msg("t1", 0, MSG_123456);
        check("t1_first", (pc.size() > 0) ? pc[0] : -1, n0 + 1);
        check("t1_span", (pc.size() > 9) ? pc[9] - pc[0] : -1, 9);
        check("t1_idle", busy, 0);

        // stall at idx 4
        clear_log();
        full_push = 0;
        pulse_print();
        wait_q(4, 20);
        fifo.fifo_full = 1'b1;
        ticks(5);
        check("t2_held", q.size(), 4);
        fifo.fifo_full = 1'b0;
        ticks(12);
        check("t2_count", q.size(), 10);
        check_msg("t2", 0, MSG_123456);
        check("t2_full_push", full_push, 0);

        // echo and print in same cycle
        clear_log();
        echo_data  = 8'h41;
        echo_valid = 1'b1;
        print_req  = 1'b1;
        tick();
        echo_valid = 1'b0;
        print_req  = 1'b0;
        ticks(15);
        check("t3_count", q.size(), 11);
        check("t3_echo", (q.size() > 0) ? q[0] : 8'hXX, 8'h41);
        check_msg("t3", 1, MSG_123456);

        // two echoes during a message
        clear_log();
        drops = 0;
        pulse_print();
        wait_q(2, 20);
        echo_data  = 8'h61;
        echo_valid = 1'b1;
        tick();
        echo_data  = 8'h62;
        tick();
        echo_valid = 1'b0;
        ticks(15);
        check("t4_drops", drops, 1);
        check("t4_count", q.size(), 11);
        check_msg("t4", 0, MSG_123456);
        check("t4_echo", (q.size() > 10) ? q[10] : 8'hXX, 8'h61);

        // reset after third byte, with a print also pending
        clear_log();
        pulse_print();
        wait_q(2, 20);
        print_req = 1'b1;
        tick();
        print_req = 1'b0;
        wait_q(3, 20);
        reset = 1'b1;
        tick();
        check("t5_push", fifo.fifo_push, 0);
        check("t5_wdata", fifo.fifo_wdata, 0);
        check("t5_busy", busy, 0);
        check("t5_drop", echo_drop, 0);
        reset = 1'b0;
        ticks(20);
        check("t5_count", q.size(), 3);
        check("t5_idle", busy, 0);
`else
        // periodic print, period 20
        data_hour = 5'd0;
        data_min  = 6'd0;
        data_sec  = 6'd7;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_log();
        ticks(70);
        check("t6_count_ge30", q.size() >= 30, 1);
        check_msg("t6a", 0, MSG_000007);
        check_msg("t6b", 10, MSG_000007);
        check("t6_gap1", (pc.size() > 10) ? pc[10] - pc[0] : -1, 20);
        check("t6_gap2", (pc.size() > 20) ? pc[20] - pc[10] : -1, 20);
        check("t6_span", (pc.size() > 9) ? pc[9] - pc[0] : -1, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
